picoblaze_rx_fifo_port: RTL and testbench
=========================================

// Module: picoblaze_rx_fifo_port
// PURPOSE
//   Port-mapped receive peripheral on the PacoBlaze3 I/O bus; it is the responder to the processor's INPUT/OUTPUT cycles.
//   An external producer pushes bytes into a DEPTH-entry FIFO. The processor pops them through a data port, reads
//   status through a status port, and controls the block through a control port.
//   The block raises the processor interrupt while data is pending and clears it on interrupt_ack.
// PARAMETERS
//   DEPTH        16     FIFO entries; power of 2, 2..16
//   ADDR_W       4      log2(DEPTH)
//   DATA_PORT    8'h00  read: pop FIFO head
//   STATUS_PORT  8'h01  read: status byte
//   CTRL_PORT    8'h81  write: control byte
// PORTS
//   clk            in   1  system clock
//   reset_n        in   1  asynchronous, active-low reset
//   port_id        in   8  processor port address
//   read_strobe    in   1  processor INPUT strobe, 1 cycle
//   write_strobe   in   1  processor OUTPUT strobe, 1 cycle
//   out_port       in   8  processor write data
//   in_port        out  8  registered read data to processor
//   interrupt      out  1  interrupt request to processor
//   interrupt_ack  in   1  processor acknowledge, 1 cycle
//   wr_data        in   8  producer byte
//   wr_valid       in   1  producer push request
//   wr_ready       out  1  FIFO can accept a byte (= !full)
// BEHAVIOUR
//   Reset (reset_n low, async): FIFO empty, count=0, rd/wr pointers=0, in_port=8'h00, interrupt=0, int_en=0, overflow=0.
//     Reset mid-operation discards all stored data immediately.
//   Push: wr_valid & !full -> store wr_data at wr_ptr, wr_ptr++ (wraps modulo DEPTH).
//     wr_valid & full -> byte dropped, overflow<=1 (sticky).
//   Read mux (pipelined, 1-cycle latency): every posedge, in_port <= f(port_id):
//     DATA_PORT   -> head byte; 8'h00 if empty
//     STATUS_PORT -> {count[4:0], overflow, full, empty}; count zero-extended to 5 bits
//     other       -> 8'h00
//   Pop: read_strobe & port_id==DATA_PORT & !empty -> rd_ptr++ (wraps), count--. Pop when empty: no effect.
//   Simultaneous push and pop: both occur, count unchanged. When full, the push is still refused in that cycle:
//     wr_ready is evaluated before the pop.
//   count range 0..DEPTH, width ADDR_W+1; full = (count==DEPTH), empty = (count==0).
//   Control write: write_strobe & port_id==CTRL_PORT:
//     bit0 -> int_en <= out_port[0]
//     bit1 = 1 -> flush (pointers and count to 0, same cycle); a push in the same cycle is discarded
//     bit2 = 1 -> overflow <= 0; an overflow event in the same cycle wins (overflow stays 1)
//   Interrupt register, priority order each posedge:
//     1. interrupt_ack        -> interrupt <= 0
//     2. else int_en & !empty -> interrupt <= 1
//     3. else                 -> interrupt <= 0
//     Consequence: after an ack with data still pending, interrupt reasserts on the following cycle.
//   Writes to other port_ids and reads of other ports have no side effects. Status reads never pop.
// TESTING
//   1. Reset release, read STATUS_PORT -> in_port = 8'h01 one cycle after port_id set; wr_ready=1, interrupt=0.
//   2. Push 0xA5, 0x3C; read DATA_PORT with read_strobe twice -> 0xA5 then 0x3C; status then 8'h01.
//   3. Push 17 bytes 0x00..0x10 with DEPTH=16 -> wr_ready=0 after 16th push; status=8'h86
//      (count 16, overflow, full); pops return 0x00..0x0F; CTRL write 8'h04 -> status 8'h01.
//   4. CTRL write 8'h01, push 0x55 -> interrupt=1 next cycle; pulse interrupt_ack -> interrupt 0 one cycle, then back to 1;
//      pop 0x55, ack -> interrupt stays 0.
//   5. FIFO full: wr_valid and a DATA_PORT pop in the same cycle -> count 16->15, pushed byte dropped, overflow=1.
//      Count 5: push and pop together -> count stays 5, order preserved across pointer wrap.
//   6. 3 bytes queued, CTRL write 8'h02 -> status 8'h01. Assert reset_n low mid-push -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/picoblaze_rx_fifo_port.sv
// picoblaze_rx_fifo_port
// Receive FIFO peripheral on the PicoBlaze/PacoBlaze3 port bus. A producer pushes
// bytes in. The processor pops them through DATA_PORT, reads status through
// STATUS_PORT and controls the block through CTRL_PORT. An interrupt is raised
// while data is pending and interrupts are enabled.
module picoblaze_rx_fifo_port #(
  parameter int         DEPTH       = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] DATA_PORT   = 8'h00,
  parameter logic [7:0] STATUS_PORT = 8'h01,
  parameter logic [7:0] CTRL_PORT   = 8'h81
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              int_en_q, int_en_d;
  logic              interrupt_q, interrupt_d;
  logic [7:0]        in_port_q, in_port_d;
  logic [7:0]        mem_q [DEPTH];

  logic       full, empty, push, pop, ctrl_wr, flush;
  logic [4:0] count5;

  // Decode bus strobes and compute the next state of pointers, flags and read data
  always_comb begin
    full        = (count_q == (ADDR_W+1)'(DEPTH));
    empty       = (count_q == '0);
    push        = wr_valid && !full;
    pop         = read_strobe && (port_id == DATA_PORT) && !empty;
    ctrl_wr     = write_strobe && (port_id == CTRL_PORT);
    flush       = ctrl_wr && out_port[1];
    count5      = 5'(count_q);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    int_en_d    = int_en_q;
    interrupt_d = 1'b0;
    in_port_d   = 8'h00;

    // Flush overrides any push or pop in the same cycle
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end

    // A dropped byte in the same cycle as a clear leaves overflow set
    if (ctrl_wr && out_port[2]) overflow_d = 1'b0;
    if (wr_valid && full)       overflow_d = 1'b1;

    if (ctrl_wr) int_en_d = out_port[0];

    if (interrupt_ack)             interrupt_d = 1'b0;
    else if (int_en_q && !empty)   interrupt_d = 1'b1;

    if (port_id == DATA_PORT)        in_port_d = empty ? 8'h00 : mem_q[rd_ptr_q];
    else if (port_id == STATUS_PORT) in_port_d = {count5, overflow_q, full, empty};
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      int_en_q    <= 1'b0;
      interrupt_q <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      int_en_q    <= int_en_d;
      interrupt_q <= interrupt_d;
      in_port_q   <= in_port_d;
    end
  end

  // Storage array; contents need no reset because pointers and count define validity
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign in_port   = in_port_q;
  assign interrupt = interrupt_q;
  assign wr_ready  = !full;

endmodule

// File: tb/tb_picoblaze_rx_fifo_port.sv
// tb_picoblaze_rx_fifo_port
// Drives one bus cycle at a time, predicts the registered read data with a small
// queue model and checks it through a scoreboard queue.
module tb_picoblaze_rx_fifo_port;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] modelQ [$];
  logic [7:0] expQ   [$];
  logic       modelOvf;
  logic       modelIntEn;
  logic       modelInt;
  logic [7:0] lastIn;

  picoblaze_rx_fifo_port dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Clear the model to the post-reset state
  task automatic resetModel();
    modelQ.delete();
    expQ.delete();
    modelOvf   = 1'b0;
    modelIntEn = 1'b0;
    modelInt   = 1'b0;
  endtask

  // One bus cycle: predict, drive, clock, then compare the scoreboard entry
  task automatic applyStimulus(input logic [7:0] pid, input logic rd, input logic wr,
                               input logic [7:0] wdat, input logic pv, input logic [7:0] pdat,
                               input logic ack);
    logic mFull, mEmpty, ctrl;
    logic [7:0] expIn;
    mFull  = (modelQ.size() == 16);
    mEmpty = (modelQ.size() == 0);
    if (pid == 8'h00)      expIn = mEmpty ? 8'h00 : modelQ[0];
    else if (pid == 8'h01) expIn = {5'(modelQ.size()), modelOvf, mFull, mEmpty};
    else                   expIn = 8'h00;
    expQ.push_back(expIn);
    checkOutput("wr_ready", {7'b0, wr_ready}, {7'b0, !mFull});

    ctrl = wr && (pid == 8'h81);
    modelInt = ack ? 1'b0 : (modelIntEn && !mEmpty);
    if (ctrl && wdat[1]) modelQ.delete();
    else begin
      if (rd && pid == 8'h00 && !mEmpty) void'(modelQ.pop_front());
      if (pv && !mFull) modelQ.push_back(pdat);
    end
    if (ctrl && wdat[2]) modelOvf = 1'b0;
    if (pv && mFull)     modelOvf = 1'b1;
    if (ctrl)            modelIntEn = wdat[0];

    port_id = pid; read_strobe = rd; write_strobe = wr; out_port = wdat;
    wr_valid = pv; wr_data = pdat; interrupt_ack = ack;
    @(posedge clk);
    @(negedge clk);
    read_strobe = 1'b0; write_strobe = 1'b0; wr_valid = 1'b0; interrupt_ack = 1'b0;
    lastIn = in_port;
    checkOutput("in_port", in_port, expQ.pop_front());
    checkOutput("interrupt", {7'b0, interrupt}, {7'b0, modelInt});
  endtask

  task automatic idle(input logic [7:0] pid);
    applyStimulus(pid, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push(input logic [7:0] b);
    applyStimulus(8'h02, 1'b0, 1'b0, 8'h00, 1'b1, b, 1'b0);
  endtask

  task automatic pop();
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ctrlWrite(input logic [7:0] v);
    applyStimulus(8'h81, 1'b0, 1'b1, v, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; wr_data = 8'h00; wr_valid = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_port", in_port, 8'h00);
    checkOutput("rst_interrupt", {7'b0, interrupt}, 8'h00);
    checkOutput("rst_wr_ready", {7'b0, wr_ready}, 8'h01);
    reset_n = 1'b1;

    // Status after reset, then two bytes in order
    idle(8'h01);
    checkOutput("status_empty", lastIn, 8'h01);
    push(8'hA5);
    push(8'h3C);
    pop();
    checkOutput("pop_a5", lastIn, 8'hA5);
    pop();
    checkOutput("pop_3c", lastIn, 8'h3C);
    idle(8'h01);
    checkOutput("status_after_pops", lastIn, 8'h01);

    // Overfill by one, then drain and clear the overflow flag
    for (int i = 0; i <= 16; i++) push(8'(i));
    idle(8'h01);
    checkOutput("status_full_ovf", lastIn, 8'h86);
    checkOutput("wr_ready_full", {7'b0, wr_ready}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      pop();
      checkOutput("drain_order", lastIn, 8'(i));
    end
    pop();
    ctrlWrite(8'h04);
    idle(8'h01);
    checkOutput("status_ovf_cleared", lastIn, 8'h01);

    // Interrupt enable, acknowledge and re-assertion
    ctrlWrite(8'h01);
    push(8'h55);
    idle(8'h01);
    checkOutput("int_raised", {7'b0, interrupt}, 8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("int_acked", {7'b0, interrupt}, 8'h00);
    idle(8'h01);
    checkOutput("int_reasserted", {7'b0, interrupt}, 8'h01);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("pop_55", lastIn, 8'h55);
    idle(8'h01);
    checkOutput("int_stays_low", {7'b0, interrupt}, 8'h00);

    // Full FIFO: push refused while a pop happens in the same cycle
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hEE, 1'b0);
    checkOutput("pop_while_full", lastIn, 8'h40);
    idle(8'h01);
    checkOutput("status_15_ovf", lastIn, 8'h7C);
    ctrlWrite(8'h07);
    idle(8'h01);
    checkOutput("status_flushed", lastIn, 8'h01);

    // Count 5 with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
    for (int i = 0; i < 20; i++)
      applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'(8'hC0 + i), 1'b0);
    idle(8'h01);
    checkOutput("status_count5", lastIn, 8'h28);
    for (int i = 0; i < 5; i++) begin
      pop();
      checkOutput("wrap_order", lastIn, 8'hC0 + 8'(15 + i));
    end

    // Flush with three bytes queued; a push in the flush cycle is discarded
    for (int i = 0; i < 3; i++) push(8'h11 * 8'(i + 1));
    applyStimulus(8'h81, 1'b0, 1'b1, 8'h03, 1'b1, 8'h77, 1'b0);
    idle(8'h01);
    checkOutput("status_flush3", lastIn, 8'h01);

    // Asynchronous reset in the middle of a push with interrupt and data pending
    push(8'h9A);
    idle(8'h00);
    checkOutput("pre_reset_int", {7'b0, interrupt}, 8'h01);
    checkOutput("pre_reset_data", lastIn, 8'h9A);
    port_id = 8'h00; wr_valid = 1'b1; wr_data = 8'h61;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_in_port", in_port, 8'h00);
    checkOutput("async_interrupt", {7'b0, interrupt}, 8'h00);
    checkOutput("async_wr_ready", {7'b0, wr_ready}, 8'h01);
    @(negedge clk);
    wr_valid = 1'b0;
    reset_n = 1'b1;
    resetModel();
    idle(8'h01);
    checkOutput("status_post_reset", lastIn, 8'h01);
    push(8'h12);
    idle(8'h00);
    checkOutput("int_en_reset", {7'b0, interrupt}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
